// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the D-cache handshake,
// the pipeline-wide memory stall and a saturating stall-cycle counter.
module ex_mem_wb_pipe #(
   parameter int DW   = 32,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_flush,
   input  logic            ex_reg_write,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic            ex_mem_to_reg,
   input  logic [4:0]      ex_wr,
   input  logic [DW-1:0]   ex_alu_result,
   input  logic [DW-1:0]   ex_store_data,
   output logic            dc_req,
   output logic            dc_we,
   output logic [DW-1:0]   dc_addr,
   output logic [DW-1:0]   dc_wdata,
   input  logic [DW-1:0]   dc_rdata,
   input  logic            dc_ready,
   output logic            mem_stall,
   output logic            M_RegWrite,
   output logic [4:0]      M_WR_out,
   output logic [DW-1:0]   m_fwd_data,
   output logic            WB_RegWrite,
   output logic [4:0]      WB_WR_out,
   output logic [DW-1:0]   wb_data,
   output logic [CNTW-1:0] stall_cnt
);

   logic          m_valid;
   logic          m_reg_write;
   logic          m_mem_read;
   logic          m_mem_write;
   logic          m_mem_to_reg;
   logic [4:0]    m_wr;
   logic [DW-1:0] m_alu_result;
   logic [DW-1:0] m_store_data;
   logic          ex_take;

   assign ex_take    = ex_valid & ~ex_flush;
   assign dc_req     = m_valid & (m_mem_read | m_mem_write);
   assign dc_we      = m_mem_write;
   assign dc_addr    = m_alu_result;
   assign dc_wdata   = m_store_data;
   assign mem_stall  = dc_req & ~dc_ready;
   assign M_RegWrite = m_valid & m_reg_write;
   assign M_WR_out   = m_wr;
   assign m_fwd_data = m_alu_result;

   // Squashed or empty EX slots enter MEM as all-zero bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid      <= 1'b0;
         m_reg_write  <= 1'b0;
         m_mem_read   <= 1'b0;
         m_mem_write  <= 1'b0;
         m_mem_to_reg <= 1'b0;
         m_wr         <= '0;
         m_alu_result <= '0;
         m_store_data <= '0;
      end else if (!mem_stall) begin
         m_valid      <= ex_take;
         m_reg_write  <= ex_take & ex_reg_write;
         m_mem_read   <= ex_take & ex_mem_read;
         m_mem_write  <= ex_take & ex_mem_write;
         m_mem_to_reg <= ex_take & ex_mem_to_reg;
         m_wr         <= ex_take ? ex_wr : '0;
         m_alu_result <= ex_take ? ex_alu_result : '0;
         m_store_data <= ex_take ? ex_store_data : '0;
      end
   end

   // A stalled MEM slot feeds WB a bubble so nothing retires twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WB_RegWrite <= 1'b0;
         WB_WR_out   <= '0;
         wb_data     <= '0;
      end else if (mem_stall) begin
         WB_RegWrite <= 1'b0;
         WB_WR_out   <= '0;
         wb_data     <= '0;
      end else begin
         WB_RegWrite <= m_valid & m_reg_write;
         WB_WR_out   <= m_wr;
         wb_data     <= m_mem_to_reg ? dc_rdata : m_alu_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (mem_stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Bench for ex_mem_wb_pipe: directed scenarios with literal expectations,
// then random traffic checked every cycle against an instruction-slot model.
module tb_ex_mem_wb_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_flush, ex_reg_write, ex_mem_read;
   logic        ex_mem_write, ex_mem_to_reg;
   logic [4:0]  ex_wr;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [31:0] dc_rdata;
   logic        dc_ready;

   logic        dc_req, dc_we, mem_stall;
   logic [31:0] dc_addr, dc_wdata;
   logic        M_RegWrite, WB_RegWrite;
   logic [4:0]  M_WR_out, WB_WR_out;
   logic [31:0] m_fwd_data, wb_data;
   logic [15:0] stall_cnt;

   logic        s_dc_req, s_dc_we, s_mem_stall;
   logic [31:0] s_dc_addr, s_dc_wdata;
   logic        s_M_RegWrite, s_WB_RegWrite;
   logic [4:0]  s_M_WR_out, s_WB_WR_out;
   logic [31:0] s_m_fwd_data, s_wb_data;
   logic [3:0]  s_stall_cnt;

   always #5 clk = ~clk;

   ex_mem_wb_pipe #(.DW(32), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_flush(ex_flush),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_wr(ex_wr), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
      .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
      .mem_stall(mem_stall), .M_RegWrite(M_RegWrite),
      .M_WR_out(M_WR_out), .m_fwd_data(m_fwd_data),
      .WB_RegWrite(WB_RegWrite), .WB_WR_out(WB_WR_out),
      .wb_data(wb_data), .stall_cnt(stall_cnt)
   );

   ex_mem_wb_pipe #(.DW(32), .CNTW(4)) dut_s (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_flush(ex_flush),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_wr(ex_wr), .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data),
      .dc_req(s_dc_req), .dc_we(s_dc_we), .dc_addr(s_dc_addr),
      .dc_wdata(s_dc_wdata), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
      .mem_stall(s_mem_stall), .M_RegWrite(s_M_RegWrite),
      .M_WR_out(s_M_WR_out), .m_fwd_data(s_m_fwd_data),
      .WB_RegWrite(s_WB_RegWrite), .WB_WR_out(s_WB_WR_out),
      .wb_data(s_wb_data), .stall_cnt(s_stall_cnt)
   );

   typedef struct packed {
      logic        v;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        m2r;
      logic [4:0]  wr;
      logic [31:0] alu;
      logic [31:0] sd;
   } ins_t;

   // Model: the instruction occupying MEM, the last retirement, stall total.
   ins_t        mi;
   logic        r_we;
   logic [4:0]  r_wr;
   logic [31:0] r_data;
   int          stalls;
   logic        last_stall;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mi         = '0;
      r_we       = 1'b0;
      r_wr       = '0;
      r_data     = '0;
      stalls     = 0;
      last_stall = 1'b0;
   endtask

   task automatic compare(output logic stall);
      logic mem_op;
      mem_op = mi.v && (mi.mr || mi.mw);
      stall  = mem_op && !dc_ready;
      chk("dc_req", 64'(dc_req), 64'(mem_op));
      chk("dc_we", 64'(dc_we), 64'(mi.mw));
      chk("dc_addr", 64'(dc_addr), 64'(mi.alu));
      chk("dc_wdata", 64'(dc_wdata), 64'(mi.sd));
      chk("mem_stall", 64'(mem_stall), 64'(stall));
      chk("M_RegWrite", 64'(M_RegWrite), 64'(mi.v && mi.rw));
      chk("M_WR_out", 64'(M_WR_out), 64'(mi.wr));
      chk("m_fwd_data", 64'(m_fwd_data), 64'(mi.alu));
      chk("WB_RegWrite", 64'(WB_RegWrite), 64'(r_we));
      chk("WB_WR_out", 64'(WB_WR_out), 64'(r_wr));
      chk("wb_data", 64'(wb_data), 64'(r_data));
      chk("stall_cnt", 64'(stall_cnt),
          64'((stalls > 65535) ? 65535 : stalls));
      chk("stall_cnt_sat4", 64'(s_stall_cnt),
          64'((stalls > 15) ? 15 : stalls));
   endtask

   // Called just after a negedge with inputs already driven.
   task automatic tick();
      logic stall;
      ins_t nx;
      #1;
      compare(stall);
      nx.v   = ex_valid && !ex_flush;
      nx.rw  = nx.v && ex_reg_write;
      nx.mr  = nx.v && ex_mem_read;
      nx.mw  = nx.v && ex_mem_write;
      nx.m2r = nx.v && ex_mem_to_reg;
      nx.wr  = nx.v ? ex_wr : 5'd0;
      nx.alu = nx.v ? ex_alu_result : 32'd0;
      nx.sd  = nx.v ? ex_store_data : 32'd0;
      @(posedge clk);
      if (stall) begin
         stalls++;
         r_we   = 1'b0;
         r_wr   = '0;
         r_data = '0;
      end else begin
         r_we   = mi.v && mi.rw;
         r_wr   = mi.wr;
         r_data = mi.m2r ? dc_rdata : mi.alu;
         mi     = nx;
      end
      last_stall = stall;
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic fl, input logic rw,
                        input logic mr, input logic mw, input logic [4:0] wr,
                        input logic [31:0] alu, input logic [31:0] sd);
      ex_valid      = v;
      ex_flush      = fl;
      ex_reg_write  = rw;
      ex_mem_read   = mr;
      ex_mem_write  = mw;
      ex_mem_to_reg = mr;
      ex_wr         = wr;
      ex_alu_result = alu;
      ex_store_data = sd;
   endtask

   task automatic bubble();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_dc_req"}, 64'(dc_req), 64'd0);
      chk({tag, "_mem_stall"}, 64'(mem_stall), 64'd0);
      chk({tag, "_dc_addr"}, 64'(dc_addr), 64'd0);
      chk({tag, "_M_RegWrite"}, 64'(M_RegWrite), 64'd0);
      chk({tag, "_M_WR_out"}, 64'(M_WR_out), 64'd0);
      chk({tag, "_WB_RegWrite"}, 64'(WB_RegWrite), 64'd0);
      chk({tag, "_WB_WR_out"}, 64'(WB_WR_out), 64'd0);
      chk({tag, "_wb_data"}, 64'(wb_data), 64'd0);
      chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      dc_ready = 1'b0;
      dc_rdata = '0;
      bubble();
      model_reset();
      repeat (2) @(negedge clk);
      all_zero("reset");
      rst_n = 1'b1;

      // ALU pipe
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h10, 32'h0);
      tick();
      chk("alu_m_rw", 64'(M_RegWrite), 64'd1);
      chk("alu_m_wr", 64'(M_WR_out), 64'd3);
      chk("alu_m_fwd", 64'(m_fwd_data), 64'h10);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 32'h20, 32'h0);
      tick();
      chk("alu_wb_wr", 64'(WB_WR_out), 64'd3);
      chk("alu_wb_data", 64'(wb_data), 64'h10);
      chk("alu_m_wr2", 64'(M_WR_out), 64'd4);

      // Load hit
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h40, 32'h0);
      tick();
      bubble();
      dc_ready = 1'b1;
      dc_rdata = 32'hDEADBEEF;
      #1;
      chk("hit_req", 64'(dc_req), 64'd1);
      chk("hit_addr", 64'(dc_addr), 64'h40);
      chk("hit_stall", 64'(mem_stall), 64'd0);
      tick();
      chk("hit_wb_rw", 64'(WB_RegWrite), 64'd1);
      chk("hit_wb_wr", 64'(WB_WR_out), 64'd5);
      chk("hit_wb_data", 64'(wb_data), 64'hDEADBEEF);
      chk("hit_cnt", 64'(stall_cnt), 64'd0);

      // Load miss: three wait cycles, then complete
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 32'h44, 32'h0);
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h77, 32'h0);
      dc_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("miss_wb_rw", 64'(WB_RegWrite), 64'd0);
         chk("miss_hold_wr", 64'(M_WR_out), 64'd6);
      end
      dc_ready = 1'b1;
      dc_rdata = 32'hCAFEF00D;
      tick();
      chk("miss_wb_rw1", 64'(WB_RegWrite), 64'd1);
      chk("miss_wb_wr", 64'(WB_WR_out), 64'd6);
      chk("miss_wb_data", 64'(wb_data), 64'hCAFEF00D);
      chk("miss_next_m", 64'(M_WR_out), 64'd7);
      chk("miss_cnt", 64'(stall_cnt), 64'd3);
      bubble();
      tick();
      chk("miss_once_wr", 64'(WB_WR_out), 64'd7);
      chk("miss_once_data", 64'(wb_data), 64'h77);

      // Store followed by a flushed instruction
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h80, 32'h1234);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 32'h0);
      #1;
      chk("st_we", 64'(dc_we), 64'd1);
      chk("st_addr", 64'(dc_addr), 64'h80);
      chk("st_wdata", 64'(dc_wdata), 64'h1234);
      tick();
      chk("fl_m_rw", 64'(M_RegWrite), 64'd0);
      chk("fl_m_wr", 64'(M_WR_out), 64'd0);
      chk("st_no_wb", 64'(WB_RegWrite), 64'd0);

      // Saturation: 20 wait cycles on the 4-bit counter copy
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd11, 32'h100, 32'h0);
      tick();
      bubble();
      dc_ready = 1'b0;
      repeat (20) tick();
      chk("sat_cnt4", 64'(s_stall_cnt), 64'd15);
      chk("sat_cnt16", 64'(stall_cnt), 64'd23);
      dc_ready = 1'b1;
      tick();

      // Reset in the middle of an outstanding access
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd10, 32'h48, 32'h0);
      tick();
      bubble();
      dc_ready = 1'b0;
      #1;
      chk("rst_req_pre", 64'(dc_req), 64'd1);
      rst_n = 1'b0;
      #1;
      all_zero("midrst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_cnt_after", 64'(stall_cnt), 64'd0);

      // Random traffic; EX is held while the previous cycle stalled
      for (int n = 0; n < 3000; n++) begin
         if (!last_stall) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0,
                  kind != 2'd2, kind == 2'd1, kind == 2'd2,
                  5'($urandom), $urandom, $urandom);
         end
         dc_ready = $urandom_range(0, 2) != 0;
         dc_rdata = $urandom;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
